vote_collector: RTL and testbench

//   Upstream stage of the election result logic (codigojunto).

---
 rtl/vote_collector_if.sv | 25 ++
 rtl/vote_collector.sv | 154 +++++++++++++++
 tb/tb_vote_collector.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vote_collector_if.sv
// Ballot stream handshake between an upstream ballot source and the vote collector.
// The master presents a ballot with ballot_valid; the slave accepts it while ballot_ready is high.
interface vote_collector_if;
    logic       ballot_valid;
    logic       ballot_ready;
    logic [1:0] ballot_cand;
    logic       ballot_judge;
    logic [1:0] ballot_judge_id;

    modport master (
        output ballot_valid,
        output ballot_cand,
        output ballot_judge,
        output ballot_judge_id,
        input  ballot_ready
    );

    modport slave (
        input  ballot_valid,
        input  ballot_cand,
        input  ballot_judge,
        input  ballot_judge_id,
        output ballot_ready
    );
endinterface

// File: rtl/vote_collector.sv
// Vote collector: counts public ballots per candidate and records each judge's pick
// for the downstream result block, which reads the outputs once paraoif is asserted.
module vote_collector #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             open_i,
    input  logic             close_i,
    vote_collector_if.slave  bus,
    output logic [CNT_W-1:0] VA,
    output logic [CNT_W-1:0] VB,
    output logic [CNT_W-1:0] VC,
    output logic [CNT_W-1:0] VD,
    output logic [1:0]       J1,
    output logic [1:0]       J2,
    output logic [1:0]       J3,
    output logic [1:0]       J4,
    output logic [3:0]       judges_cast,
    output logic             paraoif,
    output logic             rejected,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_CLOSED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next_s;
    logic             ready_s;
    logic             accept_s;
    logic             enter_open_s;
    logic [CNT_W-1:0] tally_r [4];
    logic [1:0]       pick_r [4];
    logic [3:0]       cast_r;
    logic             paraoif_r;
    logic             rejected_r;
    logic             overflow_r;

    // A tally at its ceiling can take no further vote.
    function automatic logic tally_full(input logic [CNT_W-1:0] value);
        tally_full = (value == CNT_MAX);
    endfunction

    // Election phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Phase transitions; open wins over close while not open.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (open_i) state_next_s = ST_OPEN;
                else        state_next_s = ST_IDLE;
            end
            ST_OPEN: begin
                if (close_i) state_next_s = ST_CLOSED;
                else         state_next_s = ST_OPEN;
            end
            ST_CLOSED: begin
                if (open_i) state_next_s = ST_OPEN;
                else        state_next_s = ST_CLOSED;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake decode and the restart strobe that wipes the previous election.
    always_comb begin
        ready_s      = 1'b0;
        accept_s     = 1'b0;
        enter_open_s = 1'b0;
        if (state_r == ST_OPEN) begin
            ready_s  = 1'b1;
            accept_s = bus.ballot_valid;
        end else begin
            enter_open_s = (state_next_s == ST_OPEN);
        end
    end

    assign bus.ballot_ready = ready_s;

    // Tallies, judge picks, duplicate-judge pulse and sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                tally_r[i] <= '0;
                pick_r[i]  <= 2'b00;
            end
            cast_r     <= 4'b0000;
            rejected_r <= 1'b0;
            overflow_r <= 1'b0;
        end else if (enter_open_s) begin
            for (int i = 0; i < 4; i++) begin
                tally_r[i] <= '0;
                pick_r[i]  <= 2'b00;
            end
            cast_r     <= 4'b0000;
            rejected_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            rejected_r <= 1'b0;
            if (accept_s) begin
                if (bus.ballot_judge) begin
                    if (cast_r[bus.ballot_judge_id]) begin
                        rejected_r <= 1'b1;
                    end else begin
                        pick_r[bus.ballot_judge_id] <= bus.ballot_cand;
                        cast_r[bus.ballot_judge_id] <= 1'b1;
                    end
                end else if (tally_full(tally_r[bus.ballot_cand])) begin
                    overflow_r <= 1'b1;
                end else begin
                    tally_r[bus.ballot_cand] <= tally_r[bus.ballot_cand] + CNT_ONE;
                end
            end
        end
    end

    // Closed indication tracks the phase register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paraoif_r <= 1'b0;
        end else begin
            paraoif_r <= (state_next_s == ST_CLOSED);
        end
    end

    assign VA          = tally_r[0];
    assign VB          = tally_r[1];
    assign VC          = tally_r[2];
    assign VD          = tally_r[3];
    assign J1          = pick_r[0];
    assign J2          = pick_r[1];
    assign J3          = pick_r[2];
    assign J4          = pick_r[3];
    assign judges_cast = cast_r;
    assign paraoif     = paraoif_r;
    assign rejected    = rejected_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_vote_collector.sv
// Self-checking bench for vote_collector: directed table, corner sequences and
// randomized traffic compared against a phase/tally reference model.
module tb_vote_collector;

    logic       clk;
    logic       rst_n;
    logic       open_i;
    logic       close_i;
    logic [5:0] VA, VB, VC, VD;
    logic [1:0] J1, J2, J3, J4;
    logic [3:0] judges_cast;
    logic       paraoif, rejected, overflow;

    int checks = 0;
    int errors = 0;

    vote_collector_if bif ();

    vote_collector #(.CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .open_i      (open_i),
        .close_i     (close_i),
        .bus         (bif),
        .VA          (VA),
        .VB          (VB),
        .VC          (VC),
        .VD          (VD),
        .J1          (J1),
        .J2          (J2),
        .J3          (J3),
        .J4          (J4),
        .judges_cast (judges_cast),
        .paraoif     (paraoif),
        .rejected    (rejected),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 = idle, 1 = open, 2 = closed.
    int       m_v [4];
    int       m_j [4];
    bit [3:0] m_cast;
    int       m_phase;
    bit       m_ovf;
    bit       m_rej;

    typedef struct {
        logic       open;
        logic       close;
        logic       valid;
        logic [1:0] cand;
        logic       judge;
        logic [1:0] id;
        logic       e_ready;
        logic       e_para;
        logic       e_rej;
        logic [3:0] e_jc;
        logic [7:0] e_j;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_v[i] = 0;
            m_j[i] = 0;
        end
        m_cast  = 4'b0000;
        m_phase = 0;
        m_ovf   = 1'b0;
        m_rej   = 1'b0;
    endtask

    task automatic model_step();
        bit acc;
        acc   = bif.ballot_valid && (m_phase == 1);
        m_rej = 1'b0;
        if (acc) begin
            if (bif.ballot_judge) begin
                if (m_cast[bif.ballot_judge_id]) begin
                    m_rej = 1'b1;
                end else begin
                    m_j[bif.ballot_judge_id]    = int'(bif.ballot_cand);
                    m_cast[bif.ballot_judge_id] = 1'b1;
                end
            end else if (m_v[bif.ballot_cand] == 63) begin
                m_ovf = 1'b1;
            end else begin
                m_v[bif.ballot_cand] = m_v[bif.ballot_cand] + 1;
            end
        end
        if (m_phase != 1 && open_i) begin
            m_phase = 1;
            for (int i = 0; i < 4; i++) begin
                m_v[i] = 0;
                m_j[i] = 0;
            end
            m_cast = 4'b0000;
            m_ovf  = 1'b0;
        end else if (m_phase == 1 && close_i) begin
            m_phase = 2;
        end
    endtask

    task automatic check_all();
        chk("VA", 32'(VA), 32'(m_v[0]));
        chk("VB", 32'(VB), 32'(m_v[1]));
        chk("VC", 32'(VC), 32'(m_v[2]));
        chk("VD", 32'(VD), 32'(m_v[3]));
        chk("J1", 32'(J1), 32'(m_j[0]));
        chk("J2", 32'(J2), 32'(m_j[1]));
        chk("J3", 32'(J3), 32'(m_j[2]));
        chk("J4", 32'(J4), 32'(m_j[3]));
        chk("judges_cast", 32'(judges_cast), 32'(m_cast));
        chk("paraoif", 32'(paraoif), 32'(m_phase == 2));
        chk("rejected", 32'(rejected), 32'(m_rej));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("ready", 32'(bif.ballot_ready), 32'(m_phase == 1));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic op, input logic cl, input logic v, input logic [1:0] c,
                         input logic j, input logic [1:0] id);
        open_i              = op;
        close_i             = cl;
        bif.ballot_valid    = v;
        bif.ballot_cand     = c;
        bif.ballot_judge    = j;
        bif.ballot_judge_id = id;
    endtask

    initial begin
        // Directed judge/close sequence starting from a fresh open.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0001, 8'b00_00_00_01};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 4'b0011, 8'b00_00_01_01};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0111, 8'b00_10_01_01};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 4'b1111, 8'b00_10_01_01};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 4'b1111, 8'b00_10_01_01};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'b1111, 8'b00_10_01_01};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b1111, 8'b00_10_01_01};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'b1111, 8'b00_10_01_01};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        model_reset();
        #12;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 17 public ballots for A.
        drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        step();
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        step();
        chk("va17", 32'(VA), 32'd17);
        chk("vb0", 32'(VB), 32'd0);
        chk("ready_open", 32'(bif.ballot_ready), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        step();

        for (int r = 0; r < 9; r++) begin
            drive(tbl[r].open, tbl[r].close, tbl[r].valid, tbl[r].cand, tbl[r].judge, tbl[r].id);
            step();
            chk($sformatf("tbl%0d_ready", r), 32'(bif.ballot_ready), 32'(tbl[r].e_ready));
            chk($sformatf("tbl%0d_para", r), 32'(paraoif), 32'(tbl[r].e_para));
            chk($sformatf("tbl%0d_rej", r), 32'(rejected), 32'(tbl[r].e_rej));
            chk($sformatf("tbl%0d_jc", r), 32'(judges_cast), 32'(tbl[r].e_jc));
            chk($sformatf("tbl%0d_j", r), 32'({J4, J3, J2, J1}), 32'(tbl[r].e_j));
        end

        // Saturation of D: 64 ballots then a few more.
        drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        step();
        chk("reopen_cleared_va", 32'(VA), 32'd0);
        for (int i = 0; i < 67; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0);
            step();
            if (i == 62) chk("vd63_no_ovf", 32'(overflow), 32'd0);
            if (i == 63) chk("vd63_ovf", 32'({VD, overflow}), 32'({6'd63, 1'b1}));
        end
        chk("vd_hold", 32'(VD), 32'd63);

        // Ballot in the same cycle as close is counted; later ones are ignored.
        drive(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0);
        step();
        chk("close_cnt_vb", 32'(VB), 32'd1);
        chk("close_para", 32'(paraoif), 32'd1);
        chk("close_ready", 32'(bif.ballot_ready), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) step();
        chk("closed_vb_hold", 32'(VB), 32'd1);

        // Asynchronous reset in the middle of an election.
        drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        step();
        drive(1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2);
        step();
        drive(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0);
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("async_vc", 32'(VC), 32'd0);
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        step();
        chk("post_rst_ready", 32'(bif.ballot_ready), 32'd1);

        // Randomized traffic; a stalled ballot is held stable until accepted.
        for (int n = 0; n < 1500; n++) begin
            open_i  = ($urandom_range(0, 24) == 0);
            close_i = ($urandom_range(0, 39) == 0);
            if (!(bif.ballot_valid && !bif.ballot_ready)) begin
                bif.ballot_valid    = ($urandom_range(0, 2) != 0);
                bif.ballot_cand     = 2'($urandom_range(0, 3));
                bif.ballot_judge    = ($urandom_range(0, 4) == 0);
                bif.ballot_judge_id = 2'($urandom_range(0, 3));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
